// File: rtl/adder_accumulator_top_if.sv
// rtl/adder_accumulator_top_if.sv - board I/O bundle for the adder/accumulator
interface adder_accumulator_top_if;
  logic [3:0] btn;
  logic [7:0] sw;
  logic [7:0] Led;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output btn,
    output sw,
    input  Led,
    input  seg,
    input  an,
    input  dp
  );

  modport slave (
    input  btn,
    input  sw,
    output Led,
    output seg,
    output an,
    output dp
  );
endinterface

// File: rtl/adder_accumulator_top.sv
// rtl/adder_accumulator_top.sv - button-driven 8-bit operand / 32-bit accumulator with hex display
module adder_accumulator_top #(
  parameter int SYNC_STAGES   = 2,
  parameter int SCAN_DIV_BITS = 16
) (
  input logic                     MCLK,
  input logic                     rst_n,
  adder_accumulator_top_if.slave  bus
);

  // btn[3] has no function on this board
  logic unused_btn3;
  assign unused_btn3 = bus.btn[3];

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [2:0]                  pulse;
  logic                        clr_p, ld_p, add_p;

  logic [7:0]  reg1_q;
  logic [31:0] acc_q;
  logic [15:0] cnt_q;

  logic [SCAN_DIV_BITS+1:0] scan_q;
  logic [1:0]               digit_sel;
  logic [15:0]              disp_val;
  logic [3:0]               nibble;
  logic [3:0]               an_d;
  logic [6:0]               seg_d;

  // Synchronize the three functional buttons and remember the last synced level
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn[2:0]};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse per press, no matter how long the button is held
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign clr_p = pulse[0];
  assign ld_p  = pulse[1];
  assign add_p = pulse[2];

  // Operand, accumulator and add counter; clear overrides load/add, add sees the pre-load operand
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      reg1_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (clr_p) begin
      reg1_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (ld_p) begin
        reg1_q <= bus.sw;
      end
      if (add_p) begin
        acc_q <= acc_q + {24'b0, reg1_q};
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Free-running scan counter; its top two bits choose the lit digit
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  assign digit_sel = scan_q[SCAN_DIV_BITS+1 -: 2];

  // Pick the 16-bit view, then the nibble and anode for the current digit
  always_comb begin
    disp_val = acc_q[15:0];
    case (bus.sw[1:0])
      2'd0: disp_val = acc_q[15:0];
      2'd1: disp_val = acc_q[31:16];
      2'd2: disp_val = {8'b0, reg1_q};
      2'd3: disp_val = cnt_q;
      default: disp_val = acc_q[15:0];
    endcase
    nibble = disp_val[3:0];
    an_d   = 4'b1110;
    case (digit_sel)
      2'd0: begin nibble = disp_val[3:0];   an_d = 4'b1110; end
      2'd1: begin nibble = disp_val[7:4];   an_d = 4'b1101; end
      2'd2: begin nibble = disp_val[11:8];  an_d = 4'b1011; end
      2'd3: begin nibble = disp_val[15:12]; an_d = 4'b0111; end
      default: begin nibble = disp_val[3:0]; an_d = 4'b1110; end
    endcase
  end

  // Hex to active-low gfedcba segments
  always_comb begin
    seg_d = 7'b1000000;
    case (nibble)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1000000;
    endcase
  end

  assign bus.Led = reg1_q;
  assign bus.seg = seg_d;
  assign bus.an  = an_d;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_adder_accumulator_top.sv
// tb/tb_adder_accumulator_top.sv - randomized self-checking bench for adder_accumulator_top
module tb_adder_accumulator_top;

  localparam int SYNC = 2;
  localparam int SDB  = 1;

  logic MCLK  = 1'b0;
  logic rst_n = 1'b0;

  adder_accumulator_top_if bus ();

  adder_accumulator_top #(
    .SYNC_STAGES   (SYNC),
    .SCAN_DIV_BITS (SDB)
  ) dut (
    .MCLK  (MCLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_reg1;
  logic [31:0] m_acc;
  logic [15:0] m_cnt;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg1 = '0;
    m_acc  = '0;
    m_cnt  = '0;
  endtask

  task automatic model_press(input logic [3:0] b, input logic [7:0] d);
    logic [7:0] old;
    old = m_reg1;
    if (b[0]) begin
      model_reset();
    end else begin
      if (b[1]) m_reg1 = d;
      if (b[2]) begin
        m_acc = m_acc + 32'(old);
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  function automatic logic [15:0] model_view(input logic [1:0] sel);
    case (sel)
      2'd0: return m_acc[15:0];
      2'd1: return m_acc[31:16];
      2'd2: return {8'h00, m_reg1};
      default: return m_cnt;
    endcase
  endfunction

  task automatic press(input logic [3:0] b, input logic [7:0] d, input int hold);
    @(posedge MCLK); #1;
    bus.sw  = d;
    bus.btn = b;
    repeat (hold) @(posedge MCLK);
    #1 bus.btn = 4'b0;
    repeat (SYNC + 2) @(posedge MCLK);
    model_press(b, d);
    @(negedge MCLK);
    check_val("led", 32'(bus.Led), 32'(m_reg1));
  endtask

  task automatic check_view(input logic [1:0] sel);
    logic [15:0] ev;
    logic [3:0]  seen;
    logic [3:0]  nib;
    int          idx;
    @(posedge MCLK); #1;
    bus.sw = {6'b0, sel};
    repeat (2) @(posedge MCLK);
    ev   = model_view(sel);
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge MCLK);
      case (bus.an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      check_val($sformatf("an_onehot_v%0d", sel), 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        nib = ev[idx*4 +: 4];
        seen[idx] = 1'b1;
        check_val($sformatf("seg_v%0d_d%0d", sel, idx), 32'(bus.seg), 32'(hex_tbl[nib]));
      end
    end
    check_val($sformatf("digits_seen_v%0d", sel), 32'(seen), 32'hF);
    check_val("dp", 32'(bus.dp), 32'd1);
  endtask

  task automatic check_all_views();
    for (int s = 0; s < 4; s++) check_view(2'(s));
  endtask

  initial begin
    logic [3:0] mask;
    int         r;
    bus.btn = 4'b0;
    bus.sw  = 8'h01;
    model_reset();

    // reset state, asserted from time zero
    #2;
    check_val("rst_led", 32'(bus.Led), 32'h0);
    check_val("rst_an", 32'(bus.an), 32'hE);
    check_val("rst_seg", 32'(bus.seg), 32'(hex_tbl[0]));
    check_val("rst_dp", 32'(bus.dp), 32'd1);
    bus.sw = 8'h00;
    #20 rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge MCLK);
      check_val($sformatf("scan_an_%0d", n), 32'(bus.an), 32'(4'hF & ~(4'b0001 << ((n >> 1) & 3))));
      check_val("scan_seg_zero", 32'(bus.seg), 32'(hex_tbl[0]));
    end

    // load held for several cycles, then single adds
    press(4'b0010, 8'h02, 4);
    check_view(2'd0);
    press(4'b0100, 8'h00, 1);
    check_view(2'd0);
    press(4'b0100, 8'h00, 1);
    check_view(2'd3);
    check_view(2'd0);
    press(4'b0100, 8'h00, 50);
    check_view(2'd0);
    check_view(2'd3);

    // accumulate across the 16-bit boundary
    press(4'b0001, 8'h00, 1);
    press(4'b0010, 8'hFF, 1);
    for (int i = 0; i < 258; i++) press(4'b0100, 8'h00, 1);
    check_all_views();

    // clear wins over a simultaneous add
    press(4'b0101, 8'h00, 1);
    check_all_views();

    // load and add together: add uses the old operand
    press(4'b0010, 8'h03, 1);
    press(4'b0110, 8'h05, 1);
    check_view(2'd0);
    check_view(2'd2);

    // asynchronous reset between clock edges
    press(4'b0010, 8'h5A, 1);
    @(posedge MCLK);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst_led", 32'(bus.Led), 32'h0);
    check_val("arst_an", 32'(bus.an), 32'hE);
    check_val("arst_seg", 32'(bus.seg), 32'(hex_tbl[0]));
    check_val("arst_dp", 32'(bus.dp), 32'd1);
    #2 rst_n = 1'b1;
    check_all_views();

    // randomized press sequence against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    mask = 4'b0010;
        2, 3, 4: mask = 4'b0100;
        5, 6:    mask = 4'b0110;
        7:       mask = 4'b0101;
        8:       mask = 4'b0001;
        default: mask = 4'b0011;
      endcase
      press(mask, 8'($urandom), $urandom_range(1, 6));
      check_all_views();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
